// File: rtl/instruction_fetch_stage_pkg.sv
// Shared processor definitions: opcodes, NOP word, fetch FSM states
// and a small opcode classifier used by fetch and dependency check.
package instruction_fetch_stage_pkg;

  localparam logic [5:0]  OP_LD         = 6'b010100;
  localparam logic [5:0]  OP_ST         = 6'b010101;
  localparam logic [5:0]  OP_JMP        = 6'b011000;
  localparam logic [3:0]  COND_J_PREFIX = 4'b0111;
  localparam logic [31:0] NOP           = 32'h0000_0000;

  typedef enum logic {
    RUN     = 1'b0,
    LD_HOLD = 1'b1
  } fetch_state_t;

  typedef enum logic [2:0] {
    OPC_OTHER,
    OPC_LD,
    OPC_ST,
    OPC_JMP,
    OPC_COND_J
  } opc_t;

  function automatic opc_t decode(input logic [31:0] word);
    opc_t r;
    r = OPC_OTHER;
    unique case (1'b1)
      (word[31:26] == OP_LD):         r = OPC_LD;
      (word[31:26] == OP_ST):         r = OPC_ST;
      (word[31:26] == OP_JMP):        r = OPC_JMP;
      (word[31:28] == COND_J_PREFIX): r = OPC_COND_J;
      default:                        r = OPC_OTHER;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_program_counter.sv
// Program counter register: load beats hold, hold beats increment;
// increment wraps naturally at the register width.
module program_counter
  import instruction_fetch_stage_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (!hold) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC, instruction register and the RUN/LD_HOLD FSM that
// presents each load twice and squashes the slot after a jump.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              cond_taken,
  input  logic [ADDR_W-1:0] cond_target,
  output logic [31:0]       ins,
  output logic [ADDR_W-1:0] pc_ir,
  output logic              ld_hold
);

  fetch_state_t      state;
  fetch_state_t      state_d;
  logic [31:0]       ins_d;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_ir_d;
  logic [ADDR_W-1:0] pc_target;
  logic              pc_hold;
  logic              pc_load;
  opc_t              opc;

  assign opc       = decode(ins);
  assign imem_addr = pc;
  assign ld_hold   = (state == LD_HOLD);

  program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .reset  (reset),
    .hold   (pc_hold),
    .load   (pc_load),
    .target (pc_target),
    .pc     (pc)
  );

  // Priority: redirect > stall > leave hold > jump > load > fetch
  always_comb begin
    state_d   = state;
    ins_d     = ins;
    pc_ir_d   = pc_ir;
    pc_hold   = 1'b1;
    pc_load   = 1'b0;
    pc_target = cond_target;
    if (cond_taken) begin
      state_d = RUN;
      ins_d   = NOP;
      pc_ir_d = pc;
      pc_load = 1'b1;
    end else if (stall) begin
      state_d = state;
    end else if (state == LD_HOLD) begin
      state_d = RUN;
      ins_d   = imem_rdata;
      pc_ir_d = pc;
      pc_hold = 1'b0;
    end else if (opc == OPC_JMP) begin
      ins_d     = NOP;
      pc_ir_d   = pc;
      pc_load   = 1'b1;
      pc_target = ins[ADDR_W-1:0];
    end else if (opc == OPC_LD) begin
      state_d = LD_HOLD;
    end else begin
      ins_d   = imem_rdata;
      pc_ir_d = pc;
      pc_hold = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      ins   <= NOP;
      pc_ir <= '0;
    end else begin
      state <= state_d;
      ins   <= ins_d;
      pc_ir <= pc_ir_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: directed scenarios,
// then randomized stall/redirect/reset traffic over random programs.
module tb_instruction_fetch_stage;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic          cond_taken = 1'b0;
  logic [AW-1:0] cond_target = '0;
  logic [AW-1:0] imem_addr;
  logic [AW-1:0] pc_ir;
  logic [31:0]   imem_rdata;
  logic [31:0]   ins;
  logic          ld_hold;

  logic [AW-1:0] imem_addr2;
  logic [AW-1:0] pc_ir2;
  logic [31:0]   ins2;
  logic          ld_hold2;

  logic [31:0] mem [0:65535];

  assign imem_rdata = mem[imem_addr];

  always #5 clk = ~clk;

  instruction_fetch_stage #(.ADDR_W(AW), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .cond_taken  (cond_taken),
    .cond_target (cond_target),
    .ins         (ins),
    .pc_ir       (pc_ir),
    .ld_hold     (ld_hold)
  );

  instruction_fetch_stage #(.ADDR_W(AW), .RESET_PC(16'hFFFF)) dut_wrap (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr2),
    .imem_rdata  (32'h0400_0001),
    .stall       (1'b0),
    .cond_taken  (1'b0),
    .cond_target (16'h0000),
    .ins         (ins2),
    .pc_ir       (pc_ir2),
    .ld_hold     (ld_hold2)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   ins;
    logic [AW-1:0] pc_ir;
    logic          hold;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: current word, how many non-stalled cycles it has
  // already been presented, the fetch address and its producer address.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_pc_ir;
  logic [31:0]   m_ins;
  int            m_uses;

  function automatic bit is_ld(input logic [31:0] w);
    return w[31:26] == 6'b010100;
  endfunction

  function automatic bit is_jmp(input logic [31:0] w);
    return w[31:26] == 6'b011000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; leaves the driver at the next falling edge.
  task automatic step(input logic s, input logic c, input logic [AW-1:0] t);
    stall       = s;
    cond_taken  = c;
    cond_target = t;
    if (c) begin
      m_pc_ir = m_pc;
      m_pc    = t;
      m_ins   = 32'h0;
      m_uses  = 0;
    end else if (!s) begin
      if (is_ld(m_ins) && m_uses == 0) begin
        m_uses = 1;
      end else if (is_jmp(m_ins)) begin
        m_pc_ir = m_pc;
        m_pc    = m_ins[AW-1:0];
        m_ins   = 32'h0;
        m_uses  = 0;
      end else begin
        m_ins   = mem[m_pc];
        m_pc_ir = m_pc;
        m_pc    = m_pc + 16'd1;
        m_uses  = 0;
      end
    end
    q.push_back('{m_pc, m_ins, m_pc_ir, is_ld(m_ins) && m_uses == 1});
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    stall      = 1'b0;
    cond_taken = 1'b0;
    #1;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_ins", ins, 32'h0);
    chk("rst_pc_ir", pc_ir, 32'h0);
    chk("rst_ld_hold", ld_hold, 32'h0);
    m_pc    = 16'h0000;
    m_pc_ir = 16'h0000;
    m_ins   = 32'h0;
    m_uses  = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    int r;
    logic [31:0] w;
    r = $urandom_range(0, 9);
    w = $urandom;
    case (r)
      0, 1:    rand_word = {6'b010100, w[25:0]};
      2:       rand_word = {6'b010101, w[25:0]};
      3:       rand_word = {6'b011000, 10'h0, w[15:0]};
      4:       rand_word = {4'b0111, w[27:0]};
      5:       rand_word = 32'h0;
      default: rand_word = {6'b000001, w[25:0]};
    endcase
  endfunction

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("imem_addr", imem_addr, e.addr);
      chk("ins", ins, e.ins);
      chk("pc_ir", pc_ir, e.pc_ir);
      chk("ld_hold", ld_hold, e.hold);
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0400_0000 | i;
    mem[2]     = 32'h5000_0000;
    mem[3]     = 32'h5400_0000;
    mem[4]     = 32'h7C00_0010;
    mem[5]     = 32'h6000_0040;
    mem[16'h42] = 32'h5000_0042;
    mem[16'h46] = 32'h5000_0000;
    mem[16'h4C] = 32'h5000_004C;

    @(negedge clk);
    do_reset();
    chk("wrap_rst_addr", imem_addr2, 32'hFFFF);
    step(1'b0, 1'b0, '0);
    chk("wrap_addr", imem_addr2, 32'h0000);
    chk("wrap_ins", ins2, 32'h0400_0001);
    chk("wrap_pc_ir", pc_ir2, 32'hFFFF);
    chk("wrap_ld_hold", ld_hold2, 32'h0);

    repeat (12) step(1'b0, 1'b0, '0);

    n = 0;
    while (!(is_ld(m_ins) && m_uses == 0) && n < 20) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    if (n >= 20) chk("find_ld_stall", 32'h0, 32'h1);
    repeat (3) step(1'b1, 1'b0, '0);
    repeat (4) step(1'b0, 1'b0, '0);

    n = 0;
    while (!(is_ld(m_ins) && m_uses == 1) && n < 20) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    if (n >= 20) chk("find_ld_hold", 32'h0, 32'h1);
    step(1'b1, 1'b1, 16'h0100);
    repeat (3) step(1'b0, 1'b0, '0);

    for (int i = 0; i < 65536; i++) mem[i] = rand_word();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int x;
      x = $urandom_range(0, 99);
      if (x < 1) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5,
             AW'($urandom));
      end
    end

    chk("scoreboard_drain", q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
